reg_file_alu_pipe: RTL and testbench

Parametrised successor to the single-cycle register-file/ALU datapath. It contains a 2^ADDR_W x DATA_W register file, an 8-op ALU with an immediate/register operand mux, and one registered execute stage. The execute stage provides a one-cycle ALU latency, deferred writeback, EX->read forwarding and registered Zero/Carry/Negative flags. It sits between the instruction decoder and the data-memory/branch logic in the microprocessor.

---
 rtl/reg_file_alu_pkg.sv | 27 ++
 rtl/reg_file_alu_pipe_alu.sv | 42 ++++
 rtl/reg_file_alu_pipe.sv | 92 +++++++++
 tb/tb_reg_file_alu_pipe.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_alu_pkg.sv
// reg_file_alu_pkg: shared ALU opcode enum, flag bundle and flag packing helper
package reg_file_alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
    } alu_flags_t;

    function automatic alu_flags_t pack_flags(input logic zero, input logic carry, input logic negative);
        pack_flags = {zero, carry, negative};
    endfunction

endpackage

// File: rtl/reg_file_alu_pipe_alu.sv
// alu_core: combinational 8-op ALU producing result and ADD/SUB carry-out
module alu_core
    import reg_file_alu_pkg::*;
#(
    parameter int DATA_W = 8
)(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    localparam int SH_W = $clog2(DATA_W);

    logic              is_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic [SH_W-1:0]   shamt;

    assign is_sub = (op == ALU_SUB);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    assign shamt  = b[SH_W-1:0];

    // Operation select; carry only meaningful for the adder ops
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD, ALU_SUB: result = sum[DATA_W-1:0];
            ALU_AND:          result = a & b;
            ALU_OR:           result = a | b;
            ALU_XOR:          result = a ^ b;
            ALU_SLL:          result = a << shamt;
            ALU_SRL:          result = a >> shamt;
            ALU_SLT:          result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            default:          result = '0;
        endcase
        carry = (op == ALU_ADD || is_sub) ? sum[DATA_W] : 1'b0;
    end

endmodule

// File: rtl/reg_file_alu_pipe.sv
// reg_file_alu_pipe: register file + ALU with one registered execute stage, forwarding and deferred writeback
module reg_file_alu_pipe
    import reg_file_alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
)(
    input  logic                CLK,
    input  logic                RST,
    input  logic                valid_in,
    input  logic [ADDR_W-1:0]   RA1,
    input  logic [ADDR_W-1:0]   RA2,
    input  logic [ADDR_W-1:0]   WA,
    input  logic [DATA_W-1:0]   immediate,
    input  logic [ALU_OP_W-1:0] ALUControl,
    input  logic                write_enable,
    input  logic                ALUSrc,
    output logic [DATA_W-1:0]   ALUResult,
    output logic [DATA_W-1:0]   cpu_out,
    output logic                valid_out,
    output logic                Zero,
    output logic                Carry,
    output logic                Negative
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] res_q, rd2_q;
    logic [DATA_W-1:0] res_d, rd1_d, rd2_d, b_d;
    logic [ADDR_W-1:0] ex_wa_q;
    logic              ex_valid_q, ex_we_q, carry_d, wb_en;
    alu_flags_t        flags_q, flags_d;

    // A pending EX result both forwards to the readers and retires into the RF; R0 is excluded when hardwired
    assign wb_en = ex_valid_q & ex_we_q & ~((ZERO_REG != 0) && (ex_wa_q == '0));

    // Operand read with EX forwarding taking priority over the (possibly stale) RF entry
    always_comb begin
        rd1_d   = (wb_en && ex_wa_q == RA1) ? res_q : ((ZERO_REG != 0) && RA1 == '0) ? '0 : rf_q[RA1];
        rd2_d   = (wb_en && ex_wa_q == RA2) ? res_q : ((ZERO_REG != 0) && RA2 == '0) ? '0 : rf_q[RA2];
        b_d     = ALUSrc ? immediate : rd2_d;
        flags_d = pack_flags(res_d == '0, carry_d, res_d[DATA_W-1]);
    end

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .a      (rd1_d),
        .b      (b_d),
        .op     (alu_op_e'(ALUControl)),
        .result (res_d),
        .carry  (carry_d)
    );

    // Execute stage register; result, store data and flags hold while no op issues
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_valid_q <= 1'b0;
            ex_we_q    <= 1'b0;
            ex_wa_q    <= '0;
            res_q      <= '0;
            rd2_q      <= '0;
            flags_q    <= '0;
        end else begin
            ex_valid_q <= valid_in;
            ex_we_q    <= valid_in & write_enable;
            if (valid_in) begin
                ex_wa_q <= WA;
                res_q   <= res_d;
                rd2_q   <= rd2_d;
                flags_q <= flags_d;
            end
        end
    end

    // Register file with deferred writeback of the EX result
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
        end else if (wb_en) begin
            rf_q[ex_wa_q] <= res_q;
        end
    end

    assign ALUResult = res_q;
    assign cpu_out   = rd2_q;
    assign valid_out = ex_valid_q;
    assign Zero      = flags_q.zero;
    assign Carry     = flags_q.carry;
    assign Negative  = flags_q.negative;

endmodule

// File: tb/tb_reg_file_alu_pipe.sv
// tb_reg_file_alu_pipe: directed plan plus random ops checked against a sequential-ISA reference model
module tb_reg_file_alu_pipe;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       valid_in = 1'b0;
    logic [3:0] RA1 = '0, RA2 = '0, WA = '0;
    logic [7:0] immediate = '0;
    logic [2:0] ALUControl = '0;
    logic       write_enable = 1'b0, ALUSrc = 1'b0;
    logic [7:0] ALUResult, cpu_out;
    logic       valid_out, Zero, Carry, Negative;

    int checks = 0;
    int failures = 0;

    int regs [16];
    int e_res = 0, e_cpu = 0;
    bit e_valid = 0, e_z = 0, e_c = 0, e_n = 0;

    reg_file_alu_pipe dut (
        .CLK          (CLK),
        .RST          (RST),
        .valid_in     (valid_in),
        .RA1          (RA1),
        .RA2          (RA2),
        .WA           (WA),
        .immediate    (immediate),
        .ALUControl   (ALUControl),
        .write_enable (write_enable),
        .ALUSrc       (ALUSrc),
        .ALUResult    (ALUResult),
        .cpu_out      (cpu_out),
        .valid_out    (valid_out),
        .Zero         (Zero),
        .Carry        (Carry),
        .Negative     (Negative)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural view: R0 reads as zero, every earlier op is already visible
    function automatic int rd(input int r);
        return (r == 0) ? 0 : regs[r];
    endfunction

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic alu_ref(input int op, input int a, input int b, output int r, output bit c);
        c = 0;
        case (op)
            0: begin r = (a + b) % 256; c = (a + b) > 255; end
            1: begin r = (a - b + 256) % 256; c = (a >= b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a << (b % 8)) % 256;
            6: r = a >> (b % 8);
            default: r = (sgn(a) < sgn(b)) ? 1 : 0;
        endcase
    endtask

    task automatic model_reset();
        foreach (regs[i]) regs[i] = 0;
        e_res = 0; e_cpu = 0; e_valid = 0; e_z = 0; e_c = 0; e_n = 0;
    endtask

    task automatic issue(input bit v, input int ra1, input int ra2, input int wa,
                         input int imm, input int op, input bit we, input bit src);
        int a, d2, b, r;
        bit c;
        a  = rd(ra1);
        d2 = rd(ra2);
        b  = src ? imm : d2;
        alu_ref(op, a, b, r, c);
        if (v) begin
            e_res = r; e_cpu = d2; e_z = (r == 0); e_c = c; e_n = (r >= 128);
            if (we && wa != 0) regs[wa] = r;
        end
        e_valid = v;
        valid_in = v; RA1 = 4'(ra1); RA2 = 4'(ra2); WA = 4'(wa);
        immediate = 8'(imm); ALUControl = 3'(op); write_enable = we; ALUSrc = src;
        @(posedge CLK);
        #1;
        check("valid_out", valid_out, e_valid);
        check("ALUResult", ALUResult, e_res);
        check("cpu_out", cpu_out, e_cpu);
        check("Zero", Zero, e_z);
        check("Carry", Carry, e_c);
        check("Negative", Negative, e_n);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res"}, ALUResult, 0);
        check({tag, "_cpu"}, cpu_out, 0);
        check({tag, "_valid"}, valid_out, 0);
        check({tag, "_flags"}, {Zero, Carry, Negative}, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("por");
        RST = 1'b0;

        // Immediate add, then RA2 readback two cycles later
        issue(1, 0, 0, 4, 16, 0, 1, 1);
        check("imm_add", ALUResult, 8'h10);
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        issue(1, 0, 4, 3, 0, 2, 0, 1);
        check("store_r4", cpu_out, 8'h10);

        // Back-to-back forwarding chain
        issue(1, 0, 0, 4, 16, 0, 1, 1);
        issue(1, 4, 0, 12, 5, 0, 1, 1);
        check("fwd_add", ALUResult, 8'h15);
        issue(1, 12, 4, 2, 0, 1, 1, 0);
        check("fwd_sub", ALUResult, 8'h05);

        // Flags
        issue(1, 0, 0, 1, 8'hFF, 0, 1, 1);
        issue(1, 1, 0, 1, 1, 0, 1, 1);
        check("wrap_zc", {ALUResult, Zero, Carry}, {8'h00, 1'b1, 1'b1});
        issue(1, 4, 4, 3, 0, 1, 0, 0);
        check("sub_self", {Zero, Carry}, 2'b11);
        issue(1, 0, 0, 5, 5, 0, 1, 1);
        issue(1, 5, 0, 5, 8'h10, 1, 1, 1);
        check("sub_neg", {ALUResult, Negative, Carry}, {8'hF5, 1'b1, 1'b0});

        // R0 protection
        issue(1, 0, 0, 0, 80, 0, 1, 1);
        check("r0_res", ALUResult, 80);
        issue(1, 0, 0, 3, 0, 0, 0, 1);
        check("r0_nofwd", ALUResult, 0);
        issue(1, 0, 0, 3, 0, 3, 0, 0);

        // Both operands forwarded from the same EX result
        issue(1, 0, 0, 9, 3, 0, 1, 1);
        issue(1, 9, 9, 9, 0, 0, 1, 0);
        check("dual_fwd", ALUResult, 6);

        // Shifts, SLT and valid gating
        issue(1, 0, 0, 6, 8'h81, 0, 1, 1);
        issue(1, 6, 0, 3, 1, 6, 0, 1);
        check("srl", ALUResult, 8'h40);
        issue(1, 6, 0, 3, 9, 5, 0, 1);
        check("sll", ALUResult, 8'h02);
        issue(1, 0, 0, 7, 8'hFF, 0, 1, 1);
        issue(1, 0, 0, 8, 1, 0, 1, 1);
        issue(1, 7, 8, 3, 0, 7, 0, 0);
        check("slt", ALUResult, 1);
        issue(0, 7, 7, 8, 99, 0, 1, 1);
        check("gated_hold", ALUResult, 1);
        issue(1, 8, 0, 3, 0, 0, 0, 1);
        check("gated_rf", ALUResult, 1);

        // Reset with a writeback to R4 still pending
        issue(1, 0, 0, 4, 8'h33, 0, 1, 1);
        RST = 1'b1;
        valid_in = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        issue(1, 4, 4, 3, 0, 0, 0, 1);
        check("rst_r4", {ALUResult, cpu_out}, 16'h0000);

        // Random traffic, biased to few registers for frequent forwarding
        for (int n = 0; n < 400; n++) begin
            issue($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
